// File: rtl/duty_pkg.sv
// Shared types and constants for the duty-cycle meter and its display helpers.
package duty_pkg;

  localparam int unsigned FRAME_LEN_DEF = 100;
  localparam int unsigned DUTY_W        = 7;
  localparam int unsigned BCD_W         = 8;

  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(100);

  typedef enum logic {
    HUNT,
    RUN
  } state_e;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    CORRUPT
  } slot_e;

  // A slot is active when the encoder bumped the symbol by one (mod 4).
  function automatic slot_e classify(input logic [1:0] a_q, input logic [1:0] b);
    if (b == a_q) begin
      return IDLE;
    end else if (b == 2'(a_q + 2'd1)) begin
      return ACTIVE;
    end else begin
      return CORRUPT;
    end
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Combinational 7-bit binary to two-digit BCD; values >= 100 saturate to 8'h99 with ovf_c.
module bin2bcd8
  import duty_pkg::*;
(
  input  logic [DUTY_W-1:0] bin,
  output logic [BCD_W-1:0]  bcd_c,
  output logic              ovf_c
);

  always_comb begin
    bcd_c = '0;
    ovf_c = 1'b0;
    if (bin >= DUTY_MAX) begin
      bcd_c = 8'h99;
      ovf_c = 1'b1;
    end else begin
      bcd_c = {4'(bin / DUTY_W'(10)), 4'(bin % DUTY_W'(10))};
    end
  end

endmodule

// File: rtl/duty_meter.sv
// Recovers the per-frame active-slot count of the duty encoder from its (a, b) symbol pair.
// Optional frame-shape check enabled by defining DUTY_METER_SHAPE_CHECK_EN.
module duty_meter
  import duty_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        a,
  input  logic [1:0]        b,
  input  logic              sof,
  output logic [DUTY_W-1:0] duty,
  output logic [BCD_W-1:0]  duty_bcd,
  output logic              ovf,
  output logic              valid,
  output logic              locked,
  output logic              sync_err,
  output logic              sym_err,
  output logic              shape_err
);

  localparam int unsigned    SLOT_W    = $clog2(FRAME_LEN);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);

  state_e             state_q, state_d;
  logic [1:0]         a_q;
  logic [SLOT_W-1:0]  slot_q, slot_d, cur_slot;
  logic [DUTY_W-1:0]  acc_q, acc_d, acc_base, acc_sum;
  logic [DUTY_W-1:0]  duty_d;
  logic [BCD_W-1:0]   bcd_d, bcd_c;
  logic               ovf_d, ovf_c;
  logic               valid_d, sync_err_d;
  slot_e              cls;
  logic               is_active, restart, in_frame, last_slot;

  // b lags a by one cycle at the encoder, so compare against the registered a.
  assign cls       = classify(a_q, b);
  assign is_active = (cls == ACTIVE);

  // A sof in HUNT or at a misaligned slot makes this cycle slot 0 of a fresh frame.
  assign restart   = sof && ((state_q == HUNT) || (slot_q != '0));
  assign in_frame  = (state_q == RUN) || sof;
  assign cur_slot  = restart ? '0 : slot_q;
  assign last_slot = (cur_slot == LAST_SLOT);
  assign acc_base  = restart ? '0 : acc_q;
  assign acc_sum   = (acc_base >= DUTY_MAX) ? DUTY_MAX : acc_base + DUTY_W'(is_active);

  bin2bcd8 u_bcd (
    .bin   (acc_sum),
    .bcd_c (bcd_c),
    .ovf_c (ovf_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    acc_d      = acc_q;
    duty_d     = duty;
    bcd_d      = duty_bcd;
    ovf_d      = ovf;
    valid_d    = 1'b0;
    sync_err_d = (state_q == RUN) && sof && (slot_q != '0);
    if (in_frame) begin
      state_d = RUN;
      if (last_slot) begin
        slot_d  = '0;
        acc_d   = '0;
        duty_d  = acc_sum;
        bcd_d   = bcd_c;
        ovf_d   = ovf_c;
        valid_d = 1'b1;
      end else begin
        slot_d = cur_slot + SLOT_W'(1);
        acc_d  = acc_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      a_q      <= '0;
      slot_q   <= '0;
      acc_q    <= '0;
      duty     <= '0;
      duty_bcd <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
      sym_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a;
      slot_q   <= slot_d;
      acc_q    <= acc_d;
      duty     <= duty_d;
      duty_bcd <= bcd_d;
      ovf      <= ovf_d;
      valid    <= valid_d;
      locked   <= (state_d == RUN);
      sync_err <= sync_err_d;
      sym_err  <= (cls == CORRUPT);
    end
  end

`ifdef DUTY_METER_SHAPE_CHECK_EN
  logic idle_q, idle_d, shape_q, shape_d, shape_err_d;
  logic idle_base, shape_now;

  // Encoder frames are all-active then all-idle; an active slot after any idle one breaks that.
  assign idle_base = restart ? 1'b0 : idle_q;
  assign shape_now = (restart ? 1'b0 : shape_q) | (is_active & idle_base);

  always_comb begin
    idle_d      = idle_q;
    shape_d     = shape_q;
    shape_err_d = 1'b0;
    if (in_frame) begin
      if (last_slot) begin
        idle_d      = 1'b0;
        shape_d     = 1'b0;
        shape_err_d = shape_now;
      end else begin
        idle_d  = idle_base | ~is_active;
        shape_d = shape_now;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= 1'b0;
      shape_q   <= 1'b0;
      shape_err <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      shape_q   <= shape_d;
      shape_err <= shape_err_d;
    end
  end
`else
  assign shape_err = 1'b0;
`endif

endmodule

// File: tb/tb_duty_meter.sv
// Self-checking bench for duty_meter: encoder-style frame stimulus with a result scoreboard.
module tb_duty_meter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] a = '0;
  logic [1:0] b = '0;
  logic       sof = 1'b0;
  logic [6:0] duty;
  logic [7:0] duty_bcd;
  logic       ovf, valid, locked, sync_err, sym_err, shape_err;

  always #5 clk = ~clk;

  duty_meter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .sof       (sof),
    .duty      (duty),
    .duty_bcd  (duty_bcd),
    .ovf       (ovf),
    .valid     (valid),
    .locked    (locked),
    .sync_err  (sync_err),
    .sym_err   (sym_err),
    .shape_err (shape_err)
  );

`ifdef DUTY_METER_SHAPE_CHECK_EN
  localparam bit SHAPE_ON = 1'b1;
`else
  localparam bit SHAPE_ON = 1'b0;
`endif

  typedef struct {
    logic [6:0] duty;
    logic [7:0] bcd;
    logic       ovf;
    logic       shape;
  } exp_t;

  typedef struct {
    logic [7:0] sw;
    logic [6:0] duty;
    logic [7:0] bcd;
    logic       ovf;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[8];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] prev_a = '0;

  function automatic exp_t mk(input logic [6:0] d, input logic [7:0] bcd,
                              input logic o, input logic s);
    exp_t e;
    e.duty = d; e.bcd = bcd; e.ovf = o; e.shape = s;
    return e;
  endfunction

  // Encoder threshold: BCD switch value, or 100 when the switch is not valid BCD.
  function automatic int thr_of(input logic [7:0] sw);
    if (sw[7:4] <= 4'd9 && sw[3:0] <= 4'd9) return int'(sw[7:4]) * 10 + int'(sw[3:0]);
    return 100;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one slot, wait one edge, compare per-cycle flags and pop the scoreboard on valid.
  task automatic step(input logic [1:0] av, input logic [1:0] bv, input logic sv,
                      input bit ev, input bit es, input exp_t e);
    bit   esym;
    exp_t x;
    esym = !((bv == prev_a) || (bv == 2'(prev_a + 2'd1)));
    a = av; b = bv; sof = sv;
    if (ev) sb.push_back(e);
    @(posedge clk); #1;
    prev_a = av;
    chk("valid", 32'(valid), 32'(ev));
    chk("sync_err", 32'(sync_err), 32'(es));
    chk("sym_err", 32'(sym_err), 32'(esym));
    if (valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid got duty %0d want none", duty);
      end else begin
        x = sb.pop_front();
        chk("duty", 32'(duty), 32'(x.duty));
        chk("duty_bcd", 32'(duty_bcd), 32'(x.bcd));
        chk("ovf", 32'(ovf), 32'(x.ovf));
        chk("shape_err", 32'(shape_err), 32'(x.shape));
      end
    end
  endtask

  // Encoder-style frame: slot k active when k < threshold (or k >= threshold if inv).
  task automatic frame(input logic [7:0] sw, input int corrupt, input bit inv,
                       input bit use_sof, input bit esync_first, input int nslots,
                       input bit ev_end, input exp_t e);
    int         thr;
    bit         act;
    logic [1:0] av, bv;
    thr = thr_of(sw);
    for (int k = 0; k < nslots; k++) begin
      act = inv ? (k >= thr) : (k < thr);
      av  = 2'($urandom_range(0, 3));
      bv  = (k == corrupt) ? 2'(prev_a + 2'd2) : 2'(prev_a + 2'(act));
      step(av, bv, (k == 0) && use_sof, ev_end && (k == 99), esync_first && (k == 0), e);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_duty"}, 32'(duty), 32'd0);
    chk({tag, "_bcd"}, 32'(duty_bcd), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_sync"}, 32'(sync_err), 32'd0);
    chk({tag, "_sym"}, 32'(sym_err), 32'd0);
    chk({tag, "_shape"}, 32'(shape_err), 32'd0);
  endtask

  initial begin
    exp_t none;
    none = mk(7'd0, 8'h00, 1'b0, 1'b0);
    tbl[0] = '{8'h37, 7'd37,  8'h37, 1'b0};
    tbl[1] = '{8'h00, 7'd0,   8'h00, 1'b0};
    tbl[2] = '{8'h99, 7'd99,  8'h99, 1'b0};
    tbl[3] = '{8'hAB, 7'd100, 8'h99, 1'b1};
    tbl[4] = '{8'h50, 7'd50,  8'h50, 1'b0};
    tbl[5] = '{8'h10, 7'd10,  8'h10, 1'b0};
    tbl[6] = '{8'h9A, 7'd100, 8'h99, 1'b1};
    tbl[7] = '{8'h01, 7'd1,   8'h01, 1'b0};

    @(posedge clk); #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    prev_a = '0;

    // No sof yet: meter must stay in HUNT and never report.
    frame(8'h37, -1, 1'b0, 1'b0, 1'b0, 7, 1'b0, none);
    chk("hunt_locked", 32'(locked), 32'd0);

    for (int i = 0; i < 8; i++) begin
      frame(tbl[i].sw, -1, 1'b0, 1'b1, 1'b0, 100, 1'b1,
            mk(tbl[i].duty, tbl[i].bcd, tbl[i].ovf, 1'b0));
      if (i == 0) chk("run_locked", 32'(locked), 32'd1);
    end

    // Free-running after lock: no sof needed.
    frame(8'h42, -1, 1'b0, 1'b0, 1'b0, 100, 1'b1, mk(7'd42, 8'h42, 1'b0, 1'b0));

    // Misaligned sof at slot 42 drops the partial frame and restarts there.
    frame(8'h37, -1, 1'b0, 1'b1, 1'b0, 42, 1'b0, none);
    frame(8'h37, -1, 1'b0, 1'b1, 1'b1, 100, 1'b1, mk(7'd37, 8'h37, 1'b0, 1'b0));
    chk("sync_locked", 32'(locked), 32'd1);

    // Corrupt slot inside the active run: excluded from count, breaks shape.
    frame(8'h37, 10, 1'b0, 1'b1, 1'b0, 100, 1'b1, mk(7'd36, 8'h36, 1'b0, SHAPE_ON));
    // Corrupt slot in the idle tail: count unchanged, shape intact.
    frame(8'h37, 50, 1'b0, 1'b1, 1'b0, 100, 1'b1, mk(7'd37, 8'h37, 1'b0, 1'b0));
    // Idle-then-active frame.
    frame(8'h90, -1, 1'b1, 1'b1, 1'b0, 100, 1'b1, mk(7'd10, 8'h10, 1'b0, SHAPE_ON));
    frame(8'h25, -1, 1'b0, 1'b1, 1'b0, 100, 1'b1, mk(7'd25, 8'h25, 1'b0, 1'b0));

    // Reset at slot 60: outputs clear at once, then re-hunt.
    frame(8'h37, -1, 1'b0, 1'b1, 1'b0, 60, 1'b0, none);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_a = '0;
    frame(8'h37, -1, 1'b0, 1'b0, 1'b0, 10, 1'b0, none);
    chk("rehunt_locked", 32'(locked), 32'd0);
    frame(8'h55, -1, 1'b0, 1'b1, 1'b0, 100, 1'b1, mk(7'd55, 8'h55, 1'b0, 1'b0));

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
